// File: rtl/common.sv
// Shared types for the RV64 integer pipeline.
// Decoder and execute-stage ALU agree on these op encodings.
package common;

  localparam int XLEN = 64;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_AND   = 5'd2,
    ALU_OR    = 5'd3,
    ALU_XOR   = 5'd4,
    ALU_SLL   = 5'd5,
    ALU_SRL   = 5'd6,
    ALU_SRA   = 5'd7,
    ALU_SLT   = 5'd8,
    ALU_SLTU  = 5'd9,
    ALU_PASSB = 5'd10,
    ALU_ADDW  = 5'd11,
    ALU_SUBW  = 5'd12,
    ALU_SLLW  = 5'd13,
    ALU_SRLW  = 5'd14,
    ALU_SRAW  = 5'd15,
    ALU_PASSA = 5'd16
  } alu_op_t;

  function automatic u64 sext32(input u32 v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/exec_alu.sv
// RV64 execute-stage integer ALU.
// Purely combinational; clk/rst exist only for port uniformity.
module exec_alu
  import common::*;
#(
  parameter int XLEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] ia,
  input  logic [63:0] ib,
  input  logic [4:0]  aluOp,
  output logic [63:0] aluOut
);

  logic unusedPins;
  assign unusedPins = clk ^ rst;

  alu_op_t op;
  logic [5:0] shamt;
  logic [4:0] shamtW;
  u32 addW;
  u32 subW;
  u32 sllW;
  u32 srlW;
  u32 sraW;
  logic ltS;
  logic ltU;

  assign op     = alu_op_t'(aluOp);
  assign shamt  = ib[5:0];
  assign shamtW = ib[4:0];

  // Word ops see only the low halves; sign-extension happens at the mux.
  assign addW = ia[31:0] + ib[31:0];
  assign subW = ia[31:0] - ib[31:0];
  assign sllW = ia[31:0] << shamtW;
  assign srlW = ia[31:0] >> shamtW;
  assign sraW = u32'($signed(ia[31:0]) >>> shamtW);

  assign ltS = $signed(ia) < $signed(ib);
  assign ltU = ia < ib;

  always_comb begin
    aluOut = '0;
    case (op)
      ALU_ADD:   aluOut = ia + ib;
      ALU_SUB:   aluOut = ia - ib;
      ALU_AND:   aluOut = ia & ib;
      ALU_OR:    aluOut = ia | ib;
      ALU_XOR:   aluOut = ia ^ ib;
      ALU_SLL:   aluOut = ia << shamt;
      ALU_SRL:   aluOut = ia >> shamt;
      ALU_SRA:   aluOut = u64'($signed(ia) >>> shamt);
      ALU_SLT:   aluOut = {63'd0, ltS};
      ALU_SLTU:  aluOut = {63'd0, ltU};
      ALU_PASSB: aluOut = ib;
      ALU_ADDW:  aluOut = sext32(addW);
      ALU_SUBW:  aluOut = sext32(subW);
      ALU_SLLW:  aluOut = sext32(sllW);
      ALU_SRLW:  aluOut = sext32(srlW);
      ALU_SRAW:  aluOut = sext32(sraW);
      ALU_PASSA: aluOut = ia;
      default:   aluOut = '0;
    endcase
  end

endmodule

// File: tb/tb_exec_alu.sv
// Directed-vector bench for exec_alu.
// Expected results are hand-computed constants.
module tb_exec_alu;

  logic        clk;
  logic        rst;
  logic [63:0] ia;
  logic [63:0] ib;
  logic [4:0]  aluOp;
  logic [63:0] aluOut;

  int nVec;
  int nBad;

  exec_alu dut (
    .clk    (clk),
    .rst    (rst),
    .ia     (ia),
    .ib     (ib),
    .aluOp  (aluOp),
    .aluOut (aluOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [4:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    nVec++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic addVec(
    input string       tag,
    input int          op,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [63:0] exp
  );
    vec_t v;
    v.tag = tag;
    v.op  = 5'(op);
    v.a   = a;
    v.b   = b;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    nVec  = 0;
    nBad  = 0;
    rst   = 1'b1;
    ia    = '0;
    ib    = '0;
    aluOp = 5'd0;

    addVec("add_wrap", 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    addVec("add_plain", 0, 64'd100, 64'd23, 64'd123);
    addVec("sub_wrap", 1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    addVec("and", 2, 64'hF0F0, 64'hFF00, 64'hF000);
    addVec("or", 3, 64'hF0F0, 64'hFF00, 64'hFFF0);
    addVec("xor", 4, 64'hF0F0, 64'hFF00, 64'h0FF0);
    addVec("sll_mask", 5, 64'd1, 64'h43, 64'd8);
    addVec("srl63", 6, 64'h8000_0000_0000_0000, 64'd63, 64'd1);
    addVec("sra63", 7, 64'h8000_0000_0000_0000, 64'd63,
           64'hFFFF_FFFF_FFFF_FFFF);
    addVec("sra_pos", 7, 64'h4000_0000_0000_0000, 64'd62, 64'd1);
    addVec("slt_neg", 8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
    addVec("sltu_neg", 9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    addVec("slt_eq", 8, 64'd5, 64'd5, 64'd0);
    addVec("sltu_eq", 9, 64'd5, 64'd5, 64'd0);
    addVec("sltu_lt", 9, 64'd4, 64'd5, 64'd1);
    addVec("passb", 10, 64'hDEAD, 64'h1234, 64'h1234);
    addVec("addw_ovf", 11, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000);
    addVec("addw_hi", 11, 64'hFFFF_FFFF_0000_0001, 64'd1, 64'd2);
    addVec("subw", 12, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    addVec("sllw32", 13, 64'h1234_5678_8765_4321, 64'd32,
           64'hFFFF_FFFF_8765_4321);
    addVec("sllw4", 13, 64'h0000_0000_0800_0001, 64'd4,
           64'hFFFF_FFFF_8000_0010);
    addVec("srlw", 14, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0800_0000);
    addVec("sraw", 15, 64'h0000_0001_8000_0000, 64'd4,
           64'hFFFF_FFFF_F800_0000);
    addVec("passa", 16, 64'hCAFE_F00D_1234_5678, 64'd7,
           64'hCAFE_F00D_1234_5678);
    addVec("rsvd17", 17, 64'hFFFF, 64'hFFFF, 64'd0);
    addVec("rsvd31", 31, 64'hFFFF, 64'hFFFF, 64'd0);

    // Output tracks inputs while reset is held, with no clock edge.
    @(negedge clk);
    ia    = 64'd3;
    ib    = 64'd4;
    aluOp = 5'd0;
    #1 chk("rst_add", aluOut, 64'd7);
    ia = 64'd10;
    #1 chk("rst_upd", aluOut, 64'd14);
    rst = 1'b0;
    #1 chk("rst_rel", aluOut, 64'd14);

    foreach (vecs[i]) begin
      @(negedge clk);
      ia    = vecs[i].a;
      ib    = vecs[i].b;
      aluOp = vecs[i].op;
      #1 chk(vecs[i].tag, aluOut, vecs[i].exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
